// File: rtl/trace_checker.sv
// Retirement trace checker: compares each committed instruction against a queued
// expected record and latches the first mismatch, underflow or watchdog timeout.
module trace_checker #(
  parameter int          DEPTH      = 4,
  parameter logic [15:0] MAX_CYCLES = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        commit_valid,
  input  logic [15:0] commit_pc,
  input  logic        commit_regwrite,
  input  logic        commit_memread,
  input  logic        commit_memwrite,
  input  logic        commit_halt,
  input  logic [2:0]  commit_wreg,
  input  logic [15:0] commit_wdata,
  input  logic [15:0] commit_memaddr,
  input  logic [15:0] commit_memdata,
  input  logic        exp_valid,
  output logic        exp_ready,
  input  logic [15:0] exp_pc,
  input  logic [15:0] exp_wdata,
  input  logic [15:0] exp_memaddr,
  input  logic [15:0] exp_memdata,
  input  logic [2:0]  exp_wreg,
  input  logic        exp_regwrite,
  input  logic        exp_memread,
  input  logic        exp_memwrite,
  input  logic        exp_halt,
  output logic [15:0] inst_count,
  output logic        done,
  output logic        fail,
  output logic [2:0]  err_code,
  output logic [15:0] err_inst
);

  // state  | meaning
  // S_RUN  | accepting records, checking commits, watchdog running
  // S_DONE | halt retired and matched; everything frozen
  // S_FAIL | first error latched in err_code/err_inst; everything frozen

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {S_RUN = 2'd0, S_DONE = 2'd1, S_FAIL = 2'd2} state_t;

  typedef struct packed {
    logic [15:0] pc;
    logic        regWrite;
    logic        memRead;
    logic        memWrite;
    logic        halt;
    logic [2:0]  wreg;
    logic [15:0] wdata;
    logic [15:0] memAddr;
    logic [15:0] memData;
  } rec_t;

  state_t        state, stateNext;
  rec_t          fifoMem [DEPTH];
  rec_t          head;
  rec_t          inRec;
  logic [PW-1:0] wrPtr, rdPtr;
  logic [CW-1:0] count;
  logic [15:0]   cycTimer;
  logic [15:0]   instCount;
  logic [2:0]    errCode;
  logic [15:0]   errInst;
  logic [2:0]    cmpCode;
  logic          push, pop, timeout, commitAct, empty;
  logic          underflow, mismatch, matchOk;

  assign inRec = '{pc: exp_pc, regWrite: exp_regwrite, memRead: exp_memread,
                   memWrite: exp_memwrite, halt: exp_halt, wreg: exp_wreg,
                   wdata: exp_wdata, memAddr: exp_memaddr, memData: exp_memdata};
  assign head  = fifoMem[rdPtr];
  assign empty = (count == '0);

  // Watchdog is a down-counter; terminal count 1 means this edge reaches the limit.
  assign timeout   = (state == S_RUN) && (cycTimer == 16'd1);
  assign commitAct = (state == S_RUN) && commit_valid && !timeout;
  assign push      = exp_valid && exp_ready;
  assign pop       = commitAct && !empty;
  assign underflow = commitAct && empty;
  assign mismatch  = pop && (cmpCode != 3'd0);
  assign matchOk   = pop && (cmpCode == 3'd0);

  always_comb begin
    cmpCode = 3'd0;
    if (commit_pc != head.pc)
      cmpCode = 3'd1;
    else if ({commit_regwrite, commit_memread, commit_memwrite, commit_halt} !=
             {head.regWrite, head.memRead, head.memWrite, head.halt})
      cmpCode = 3'd2;
    else if (head.regWrite && ((commit_wreg != head.wreg) || (commit_wdata != head.wdata)))
      cmpCode = 3'd3;
    else if ((head.memRead || head.memWrite) && (commit_memaddr != head.memAddr))
      cmpCode = 3'd4;
    else if (head.memWrite && (commit_memdata != head.memData))
      cmpCode = 3'd4;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_RUN;
    else     state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      S_RUN: begin
        if (timeout || underflow || mismatch) stateNext = S_FAIL;
        else if (matchOk && head.halt)        stateNext = S_DONE;
      end
      S_DONE:  stateNext = S_DONE;
      S_FAIL:  stateNext = S_FAIL;
      default: stateNext = S_RUN;
    endcase
  end

  always_comb begin
    done      = (state == S_DONE);
    fail      = (state == S_FAIL);
    exp_ready = !rst && (state == S_RUN) && (count < FULL);
  end

  always_ff @(posedge clk) begin
    if (push) fifoMem[wrPtr] <= inRec;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cycTimer  <= MAX_CYCLES;
      instCount <= '0;
      errCode   <= '0;
      errInst   <= '0;
    end else begin
      if (state == S_RUN) cycTimer <= cycTimer - 1'b1;
      if (timeout) begin
        errCode <= 3'd6;
        errInst <= instCount;
      end else if (underflow) begin
        errCode <= 3'd5;
        errInst <= instCount;
      end else if (mismatch) begin
        errCode <= cmpCode;
        errInst <= instCount;
      end else if (matchOk) begin
        instCount <= instCount + 1'b1;
      end
    end
  end

  assign inst_count = instCount;
  assign err_code   = errCode;
  assign err_inst   = errInst;

endmodule

// File: tb/tb_trace_checker.sv
// Directed bench for trace_checker: a default instance plus a short-watchdog
// instance (MAX_CYCLES=10) driven by the same stimulus.
module tb_trace_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        commit_valid, commit_regwrite, commit_memread, commit_memwrite, commit_halt;
  logic [15:0] commit_pc, commit_wdata, commit_memaddr, commit_memdata;
  logic [2:0]  commit_wreg;
  logic        exp_valid, exp_regwrite, exp_memread, exp_memwrite, exp_halt;
  logic [15:0] exp_pc, exp_wdata, exp_memaddr, exp_memdata;
  logic [2:0]  exp_wreg;

  logic        expReady, done, fail;
  logic [15:0] instCount, errInst;
  logic [2:0]  errCode;
  logic        mxReady, mxDone, mxFail;
  logic [15:0] mxInstCount, mxErrInst;
  logic [2:0]  mxErrCode;

  int nCompared   = 0;
  int nMismatched = 0;

  always #5 clk = ~clk;

  trace_checker uDut (
    .clk(clk), .rst(rst),
    .commit_valid(commit_valid), .commit_pc(commit_pc),
    .commit_regwrite(commit_regwrite), .commit_memread(commit_memread),
    .commit_memwrite(commit_memwrite), .commit_halt(commit_halt),
    .commit_wreg(commit_wreg), .commit_wdata(commit_wdata),
    .commit_memaddr(commit_memaddr), .commit_memdata(commit_memdata),
    .exp_valid(exp_valid), .exp_ready(expReady),
    .exp_pc(exp_pc), .exp_wdata(exp_wdata), .exp_memaddr(exp_memaddr),
    .exp_memdata(exp_memdata), .exp_wreg(exp_wreg),
    .exp_regwrite(exp_regwrite), .exp_memread(exp_memread),
    .exp_memwrite(exp_memwrite), .exp_halt(exp_halt),
    .inst_count(instCount), .done(done), .fail(fail),
    .err_code(errCode), .err_inst(errInst)
  );

  trace_checker #(.MAX_CYCLES(16'd10)) uMax (
    .clk(clk), .rst(rst),
    .commit_valid(commit_valid), .commit_pc(commit_pc),
    .commit_regwrite(commit_regwrite), .commit_memread(commit_memread),
    .commit_memwrite(commit_memwrite), .commit_halt(commit_halt),
    .commit_wreg(commit_wreg), .commit_wdata(commit_wdata),
    .commit_memaddr(commit_memaddr), .commit_memdata(commit_memdata),
    .exp_valid(exp_valid), .exp_ready(mxReady),
    .exp_pc(exp_pc), .exp_wdata(exp_wdata), .exp_memaddr(exp_memaddr),
    .exp_memdata(exp_memdata), .exp_wreg(exp_wreg),
    .exp_regwrite(exp_regwrite), .exp_memread(exp_memread),
    .exp_memwrite(exp_memwrite), .exp_halt(exp_halt),
    .inst_count(mxInstCount), .done(mxDone), .fail(mxFail),
    .err_code(mxErrCode), .err_inst(mxErrInst)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] want);
    nCompared++;
    if (got !== want) begin
      nMismatched++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearIn();
    commit_valid = 0; commit_pc = 0; commit_regwrite = 0; commit_memread = 0;
    commit_memwrite = 0; commit_halt = 0; commit_wreg = 0; commit_wdata = 0;
    commit_memaddr = 0; commit_memdata = 0;
    exp_valid = 0; exp_pc = 0; exp_regwrite = 0; exp_memread = 0;
    exp_memwrite = 0; exp_halt = 0; exp_wreg = 0; exp_wdata = 0;
    exp_memaddr = 0; exp_memdata = 0;
  endtask

  // flags = {regwrite, memread, memwrite, halt}
  task automatic setExp(input logic [15:0] pc, input logic [3:0] flags, input logic [2:0] wreg,
                        input logic [15:0] wdata, input logic [15:0] addr, input logic [15:0] data);
    exp_valid = 1; exp_pc = pc;
    {exp_regwrite, exp_memread, exp_memwrite, exp_halt} = flags;
    exp_wreg = wreg; exp_wdata = wdata; exp_memaddr = addr; exp_memdata = data;
  endtask

  task automatic setCommit(input logic [15:0] pc, input logic [3:0] flags, input logic [2:0] wreg,
                           input logic [15:0] wdata, input logic [15:0] addr, input logic [15:0] data);
    commit_valid = 1; commit_pc = pc;
    {commit_regwrite, commit_memread, commit_memwrite, commit_halt} = flags;
    commit_wreg = wreg; commit_wdata = wdata; commit_memaddr = addr; commit_memdata = data;
  endtask

  task automatic doReset();
    rst = 1;
    clearIn();
    tick();
    rst = 0;
  endtask

  initial begin
    clearIn();
    tick();
    checkVal("rst ready", expReady, 0);
    checkVal("rst inst", instCount, 0);
    checkVal("rst done", done, 0);
    checkVal("rst fail", fail, 0);
    checkVal("rst err", errCode, 0);
    checkVal("rst errinst", errInst, 0);
    rst = 0;

    // three-record program ending in halt
    setExp(16'h0000, 4'b1000, 3'd1, 16'h0005, 0, 0); tick();
    setExp(16'h0002, 4'b1000, 3'd2, 16'h000A, 0, 0); tick();
    setExp(16'h0004, 4'b0001, 3'd0, 16'h0000, 0, 0); tick();
    exp_valid = 0;
    checkVal("prog ready", expReady, 1);
    setCommit(16'h0000, 4'b1000, 3'd1, 16'h0005, 0, 0); tick();
    checkVal("prog inst1", instCount, 1);
    setCommit(16'h0002, 4'b1000, 3'd2, 16'h000A, 0, 0); tick();
    setCommit(16'h0004, 4'b0001, 3'd0, 16'h0000, 0, 0); tick();
    commit_valid = 0;
    checkVal("prog inst3", instCount, 3);
    checkVal("prog done", done, 1);
    checkVal("prog fail", fail, 0);
    checkVal("prog err", errCode, 0);
    checkVal("done ready", expReady, 0);
    setCommit(16'hDEAD, 4'b0000, 0, 0, 0, 0); tick();
    commit_valid = 0;
    checkVal("done sticky inst", instCount, 3);
    checkVal("done sticky", done, 1);
    checkVal("done sticky fail", fail, 0);
    #2 rst = 1;
    #1;
    checkVal("async rst done", done, 0);
    checkVal("async rst inst", instCount, 0);
    checkVal("async rst ready", expReady, 0);

    // register data mismatch
    doReset();
    setExp(16'h0002, 4'b1000, 3'd3, 16'h1234, 0, 0); tick();
    exp_valid = 0;
    setCommit(16'h0002, 4'b1000, 3'd3, 16'h1235, 0, 0); tick();
    clearIn();
    checkVal("reg fail", fail, 1);
    checkVal("reg err", errCode, 3);
    checkVal("reg errinst", errInst, 0);
    checkVal("reg done", done, 0);
    setExp(16'h0100, 4'b0000, 0, 0, 0, 0);
    setCommit(16'hAAAA, 4'b0001, 0, 0, 0, 0); tick();
    clearIn();
    checkVal("fail sticky err", errCode, 3);
    checkVal("fail sticky ready", expReady, 0);
    checkVal("fail sticky", fail, 1);

    // flag mismatch on second commit; regwrite=0 ignores wreg/wdata
    doReset();
    setExp(16'h0010, 4'b0000, 0, 0, 0, 0); tick();
    setExp(16'h0012, 4'b0100, 0, 0, 16'h0020, 0); tick();
    clearIn();
    setCommit(16'h0010, 4'b0000, 3'd7, 16'hFFFF, 0, 0); tick();
    setCommit(16'h0012, 4'b0000, 0, 0, 16'h0020, 0); tick();
    clearIn();
    checkVal("flag err", errCode, 2);
    checkVal("flag errinst", errInst, 1);
    checkVal("flag inst", instCount, 1);

    // PC mismatch
    doReset();
    setExp(16'h0010, 4'b0000, 0, 0, 0, 0); tick();
    clearIn();
    setCommit(16'h0014, 4'b0000, 0, 0, 0, 0); tick();
    clearIn();
    checkVal("pc err", errCode, 1);

    // register check outranks memory check
    doReset();
    setExp(16'h0030, 4'b1010, 3'd5, 16'h1111, 16'h0040, 16'h2222); tick();
    clearIn();
    setCommit(16'h0030, 4'b1010, 3'd6, 16'h1111, 16'h0041, 16'h2222); tick();
    clearIn();
    checkVal("prio err", errCode, 3);

    // store data mismatch
    doReset();
    setExp(16'h0020, 4'b0010, 0, 0, 16'h0040, 16'hBEEF); tick();
    clearIn();
    setCommit(16'h0020, 4'b0010, 0, 0, 16'h0040, 16'hBEEE); tick();
    clearIn();
    checkVal("store err", errCode, 4);
    checkVal("store errinst", errInst, 0);

    // load: data ignored, address checked
    doReset();
    setExp(16'h0040, 4'b0100, 0, 0, 16'h0050, 16'h0000); tick();
    setExp(16'h0042, 4'b0100, 0, 0, 16'h0060, 16'h0000); tick();
    clearIn();
    setCommit(16'h0040, 4'b0100, 0, 0, 16'h0050, 16'hFFFF); tick();
    setCommit(16'h0042, 4'b0100, 0, 0, 16'h0061, 16'h0000); tick();
    clearIn();
    checkVal("load err", errCode, 4);
    checkVal("load errinst", errInst, 1);

    // full FIFO backpressure
    doReset();
    for (int i = 0; i < 4; i++) begin
      setExp(16'h0100 + 16'(2 * i), 4'b0000, 0, 0, 0, 0); tick();
    end
    checkVal("full ready", expReady, 0);
    setExp(16'h0108, 4'b0000, 0, 0, 0, 0); tick();
    checkVal("full hold ready", expReady, 0);
    setCommit(16'h0100, 4'b0000, 0, 0, 0, 0); tick();
    commit_valid = 0;
    checkVal("pop ready", expReady, 1);
    checkVal("pop inst", instCount, 1);
    tick();
    checkVal("refill ready", expReady, 0);
    exp_valid = 0;
    for (int i = 1; i < 5; i++) begin
      setCommit(16'h0100 + 16'(2 * i), 4'b0000, 0, 0, 0, 0); tick();
    end
    clearIn();
    checkVal("drain inst", instCount, 5);
    checkVal("drain fail", fail, 0);

    // commit with empty FIFO and same-cycle push
    doReset();
    setExp(16'h0000, 4'b0000, 0, 0, 0, 0);
    setCommit(16'h0000, 4'b0000, 0, 0, 0, 0); tick();
    clearIn();
    checkVal("underflow fail", fail, 1);
    checkVal("underflow err", errCode, 5);
    checkVal("underflow inst", instCount, 0);

    // watchdog on the MAX_CYCLES=10 instance; commit at the timeout edge is ignored
    doReset();
    setExp(16'h0000, 4'b0000, 0, 0, 0, 0); tick();
    clearIn();
    repeat (8) tick();
    checkVal("wd pre fail", mxFail, 0);
    setCommit(16'h0000, 4'b0000, 0, 0, 0, 0); tick();
    clearIn();
    checkVal("wd fail", mxFail, 1);
    checkVal("wd err", mxErrCode, 6);
    checkVal("wd errinst", mxErrInst, 0);
    checkVal("wd inst", mxInstCount, 0);
    checkVal("wd main inst", instCount, 1);
    checkVal("wd main fail", fail, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
